// File: rtl/uart_alu_ctrl.sv
// Sequences UART bytes into ALU operands A, B and an opcode, then sends the
// ALU result back through the transmitter. A partial operation is dropped on an inter-byte timeout.
module uart_alu_ctrl #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy
);

    localparam int NB_CNT = $clog2(TIMEOUT_CYC + 1);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        SEND,
        WAIT_TX
    } state_t;

    state_t            state;
    logic [NB_CNT-1:0] cnt;
    logic              timeout;

    // A byte arriving on the last allowed cycle wins over the timeout.
    assign timeout = (cnt == CNT_LAST) && !i_rx_done;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= WAIT_A;
            cnt        <= '0;
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_op       <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            cnt        <= '0;
            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_data_a <= i_rx_data;
                        state    <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        o_data_b <= i_rx_data;
                        state    <= WAIT_OP;
                    end else if (timeout) begin
                        state <= WAIT_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        o_op       <= i_rx_data[NB_OP-1:0];
                        o_tx_start <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= SEND;
                    end else if (timeout) begin
                        state <= WAIT_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SEND: begin
                    // The ALU has had one cycle to settle on the new opcode.
                    o_tx_data <= i_alu_result;
                    state     <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        o_busy <= 1'b0;
                        state  <= WAIT_A;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: table-driven operations, timeout and
// reset corner cases, then random byte streams against a byte-level protocol model.
module tb_uart_alu_ctrl;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TMO     = 16;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_rx_data;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_busy;

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;
    int wide = 0;
    logic prev_start = 1'b0;

    uart_alu_ctrl #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT_CYC(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .i_alu_result(i_alu_result), .i_tx_done(i_tx_done), .o_data_a(o_data_a),
        .o_data_b(o_data_b), .o_op(o_op), .o_tx_start(o_tx_start),
        .o_tx_data(o_tx_data), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result = alu_f(o_data_a, o_data_b, o_op);

    always @(negedge i_clk) begin
        if (o_tx_start) begin
            pulses <= pulses + 1;
            if (prev_start) wide <= wide + 1;
        end
        prev_start <= o_tx_start;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_done = 1'b1;
        i_rx_data = b;
        @(posedge i_clk);
        #1;
        i_rx_done = 1'b0;
        i_rx_data = 8'($urandom);
    endtask

    task automatic finish_tx(input int w);
        idle(w);
        i_tx_done = 1'b1;
        @(posedge i_clk);
        #1;
        i_tx_done = 1'b0;
        chk("busy after tx_done", o_busy, 0);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input logic [7:0] etx, input string nm);
        int p0;
        p0 = pulses;
        send_byte(a);
        chk({nm, " data_a"}, o_data_a, a);
        chk({nm, " busy idle"}, o_busy, 0);
        send_byte(b);
        chk({nm, " data_b"}, o_data_b, b);
        send_byte(opb);
        chk({nm, " op"}, o_op, {2'b00, opb[5:0]});
        chk({nm, " tx_start"}, o_tx_start, 1);
        chk({nm, " busy send"}, o_busy, 1);
        idle(1);
        chk({nm, " tx_data"}, o_tx_data, etx);
        chk({nm, " tx_start low"}, o_tx_start, 0);
        chk({nm, " busy wait"}, o_busy, 1);
        chk({nm, " one pulse"}, pulses - p0, 1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [7:0] etx;
    } vec_t;

    vec_t vt[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int len;
        logic [7:0] ea, eb;
        logic [5:0] eop;

        vt[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
        vt[1] = '{8'h0A, 8'h03, 8'h22, 8'h07};
        vt[2] = '{8'hF0, 8'h3C, 8'h24, 8'h30};
        vt[3] = '{8'hF0, 8'h0F, 8'h25, 8'hFF};
        vt[4] = '{8'hAA, 8'hFF, 8'h26, 8'h55};
        vt[5] = '{8'h12, 8'h34, 8'hE3, 8'h00};
        vt[6] = '{8'h80, 8'h01, 8'h22, 8'h7F};
        vt[7] = '{8'hFF, 8'h01, 8'h20, 8'h00};
        vt[8] = '{8'h05, 8'h03, 8'h27, 8'hF8};

        i_rst = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00; i_tx_done = 1'b0;
        #3;
        chk("rst data_a", o_data_a, 0);
        chk("rst data_b", o_data_b, 0);
        chk("rst op", o_op, 0);
        chk("rst tx_data", o_tx_data, 0);
        chk("rst tx_start", o_tx_start, 0);
        chk("rst busy", o_busy, 0);
        #19 i_rst = 1'b1;
        @(posedge i_clk);
        #1;

        // Back-to-back table operations
        for (int i = 0; i < 9; i++) begin
            do_op(vt[i].a, vt[i].b, vt[i].opb, vt[i].etx, $sformatf("vec%0d", i));
            finish_tx(i % 3);
        end

        // Timeout in WAIT_B: 0x11 is discarded, 0x22 becomes operand A
        p0 = pulses;
        send_byte(8'h11);
        chk("tmo first A", o_data_a, 8'h11);
        idle(TMO);
        chk("tmo no pulse", pulses - p0, 0);
        chk("tmo keeps b", o_data_b, 8'h03);
        do_op(8'h22, 8'h01, 8'h20, 8'h23, "after tmo");
        finish_tx(1);

        // Byte on the last allowed cycle is accepted
        send_byte(8'h44);
        idle(TMO - 1);
        send_byte(8'h55);
        chk("edge b", o_data_b, 8'h55);
        chk("edge a", o_data_a, 8'h44);
        idle(TMO - 1);
        send_byte(8'h20);
        chk("edge tx_start", o_tx_start, 1);
        idle(1);
        chk("edge tx_data", o_tx_data, 8'h99);
        finish_tx(0);

        // Timeout in WAIT_OP
        p0 = pulses;
        send_byte(8'h10);
        send_byte(8'h20);
        idle(TMO);
        chk("tmo op no pulse", pulses - p0, 0);
        chk("tmo op keeps op", o_op, 6'h20);
        do_op(8'h30, 8'h40, 8'h22, 8'hF0, "after tmo op");
        finish_tx(2);

        // Rx while busy is dropped, including when coincident with tx_done
        do_op(8'h01, 8'h02, 8'h20, 8'h03, "drop");
        send_byte(8'h66);
        chk("drop busy rx a", o_data_a, 8'h01);
        chk("drop busy rx b", o_data_b, 8'h02);
        i_tx_done = 1'b1; i_rx_done = 1'b1; i_rx_data = 8'h7F;
        @(posedge i_clk);
        #1;
        i_tx_done = 1'b0; i_rx_done = 1'b0;
        chk("drop coincident a", o_data_a, 8'h01);
        chk("drop coincident busy", o_busy, 0);
        do_op(8'h09, 8'h01, 8'h22, 8'h08, "post drop");
        finish_tx(0);

        // Asynchronous reset in WAIT_OP
        send_byte(8'h05);
        send_byte(8'h06);
        #2 i_rst = 1'b0;
        #1;
        chk("async rst data_a", o_data_a, 0);
        chk("async rst data_b", o_data_b, 0);
        chk("async rst op", o_op, 0);
        chk("async rst tx_data", o_tx_data, 0);
        chk("async rst busy", o_busy, 0);
        idle(2);
        #3 i_rst = 1'b1;
        p0 = pulses;
        idle(5);
        chk("rst no pulse", pulses - p0, 0);
        do_op(8'h07, 8'h08, 8'h20, 8'h0F, "post rst");
        finish_tx(1);

        // Asynchronous reset in WAIT_TX; tx_done afterwards is ignored
        do_op(8'h01, 8'h01, 8'h20, 8'h02, "pre rst tx");
        #2 i_rst = 1'b0;
        #1;
        chk("rst wait_tx busy", o_busy, 0);
        chk("rst wait_tx tx_data", o_tx_data, 0);
        idle(1);
        #3 i_rst = 1'b1;
        p0 = pulses;
        idle(1);
        i_tx_done = 1'b1;
        idle(1);
        i_tx_done = 1'b0;
        idle(3);
        chk("rst tx no pulse", pulses - p0, 0);
        do_op(8'h33, 8'h01, 8'h20, 8'h34, "post rst tx");
        finish_tx(0);

        // Random byte streams against a byte-level model
        ea = 8'h33; eb = 8'h01; eop = 6'h20; len = 0;
        for (int i = 0; i < 60; i++) begin
            int gap;
            logic [7:0] b;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TMO - 2, TMO + 3))
                                              : int'($urandom_range(0, 3));
            b = 8'($urandom);
            idle(gap);
            if (len > 0 && gap >= TMO) len = 0;
            case (len)
                0:       ea = b;
                1:       eb = b;
                default: eop = b[5:0];
            endcase
            len++;
            p0 = pulses;
            send_byte(b);
            chk("rnd data_a", o_data_a, ea);
            chk("rnd data_b", o_data_b, eb);
            chk("rnd op", o_op, eop);
            if (len == 3) begin
                chk("rnd tx_start", o_tx_start, 1);
                idle(1);
                chk("rnd tx_data", o_tx_data, alu_f(ea, eb, eop));
                chk("rnd one pulse", pulses - p0, 1);
                repeat ($urandom_range(0, 4)) begin
                    if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
                    else idle(1);
                end
                i_tx_done = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    i_rx_done = 1'b1;
                    i_rx_data = 8'($urandom);
                end
                @(posedge i_clk);
                #1;
                i_tx_done = 1'b0; i_rx_done = 1'b0;
                chk("rnd busy done", o_busy, 0);
                chk("rnd a kept", o_data_a, ea);
                len = 0;
            end else begin
                chk("rnd no start", o_tx_start, 0);
            end
        end

        idle(2);
        chk("pulse width", wide, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
